// File: rtl/data_sel_wb.sv
// Write-back data selector: picks one of five datapath sources per SEL and queues {word, Dest, err}
// in a 2-entry valid/ready buffer. Define DATA_SEL_SIGNEXT_EN to sign-extend NUM instead of zero-extending it.
module data_sel_wb #(
  parameter int WIDTH  = 8,
  parameter int NUM_W  = 3,
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  DataIn,
  input  logic [WIDTH-1:0]  Direccion,
  input  logic [NUM_W-1:0]  NUM,
  input  logic [WIDTH-1:0]  RY,
  input  logic [WIDTH-1:0]  Resultado,
  input  logic [2:0]        SEL,
  input  logic [DEST_W-1:0] Dest,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  Dato_Registro,
  output logic [DEST_W-1:0] Dest_Out,
  output logic              Sel_Err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        Tx_Count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0]  word;
    logic [DEST_W-1:0] dest;
    logic              err;
  } entry_t;

  logic [WIDTH-1:0] num_ext;
  entry_t           in_entry;

  // A zero-width replication is illegal, so the pass-through case gets its own branch.
  generate
    if (NUM_W == WIDTH) begin : g_num_pass
      assign num_ext = NUM;
    end else begin : g_num_ext
`ifdef DATA_SEL_SIGNEXT_EN
      assign num_ext = {{(WIDTH-NUM_W){NUM[NUM_W-1]}}, NUM};
`else
      assign num_ext = {{(WIDTH-NUM_W){1'b0}}, NUM};
`endif
    end
  endgenerate

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_entry      = '0;
    in_entry.dest = Dest;
    case (SEL)
      3'd0:    in_entry.word = DataIn;
      3'd1:    in_entry.word = Direccion;
      3'd2:    in_entry.word = num_ext;
      3'd3:    in_entry.word = RY;
      3'd4:    in_entry.word = Resultado;
      default: in_entry.err  = 1'b1;
    endcase
  end

  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [7:0] tx_q, tx_d;
  logic       push, pop;

  assign in_ready      = (count_q != FULL);
  assign out_valid     = (count_q != EMPTY);
  assign push          = in_valid & in_ready;
  assign pop           = out_valid & out_ready;
  assign Dato_Registro = head_q.word;
  assign Dest_Out      = head_q.dest;
  assign Sel_Err       = head_q.err;
  assign Tx_Count      = tx_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    tx_d    = pop ? tx_q + 8'd1 : tx_q;
    case (count_q)
      EMPTY: if (push) begin
        head_d  = in_entry;
        count_d = ONE;
      end
      ONE: case ({push, pop})
        2'b10: begin
          tail_d  = in_entry;
          count_d = FULL;
        end
        2'b01:   count_d = EMPTY;
        2'b11:   head_d  = in_entry;
        default: count_d = ONE;
      endcase
      FULL: if (pop) begin
        head_d  = tail_q;
        count_d = ONE;
      end
      default: count_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the two storage entries are reset too, because the head drives the outputs, which must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      tx_q    <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_data_sel_wb.sv
// Self-checking bench for data_sel_wb: directed scenarios plus random traffic checked against a queue model.
module tb_data_sel_wb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in, direccion, ry, resultado;
  logic [2:0] num, sel, dest;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid, sel_err;
  logic [7:0] dato, tx;
  logic [2:0] dest_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] w;
    logic [2:0] d;
    logic       e;
  } ent_t;

  ent_t q[$];
  int   tx_exp;

  data_sel_wb #(.WIDTH(8), .NUM_W(3), .DEST_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .DataIn(data_in), .Direccion(direccion), .NUM(num), .RY(ry), .Resultado(resultado),
    .SEL(sel), .Dest(dest), .in_valid(in_valid), .in_ready(in_ready),
    .Dato_Registro(dato), .Dest_Out(dest_out), .Sel_Err(sel_err),
    .out_valid(out_valid), .out_ready(out_ready), .Tx_Count(tx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ext_num(input logic [2:0] n);
`ifdef DATA_SEL_SIGNEXT_EN
    return {{5{n[2]}}, n};
`else
    return {5'b0, n};
`endif
  endfunction

  function automatic ent_t ref_entry();
    ent_t e;
    e.d = dest;
    e.e = (sel > 3'd4);
    case (sel)
      3'd0: e.w = data_in;
      3'd1: e.w = direccion;
      3'd2: e.w = ext_num(num);
      3'd3: e.w = ry;
      3'd4: e.w = resultado;
      default: e.w = 8'h00;
    endcase
    return e;
  endfunction

  // One clock: decide pop/push from the model's own occupancy, take the edge, update the model.
  task automatic tick();
    bit   do_pop, do_push;
    ent_t e;
    do_pop  = (q.size() != 0) && out_ready;
    do_push = in_valid && (q.size() < 2);
    e = ref_entry();
    @(posedge clk);
    if (do_pop) begin
      void'(q.pop_front());
      tx_exp++;
    end
    if (do_push) q.push_back(e);
    #1;
  endtask

  task automatic randomize_sources();
    data_in   = 8'($urandom);
    direccion = 8'($urandom);
    num       = 3'($urandom);
    ry        = 8'($urandom);
    resultado = 8'($urandom);
    sel       = 3'($urandom);
    dest      = 3'($urandom);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; direccion = '0; num = '0; ry = '0; resultado = '0; sel = '0; dest = '0;
    q.delete(); tx_exp = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (dato !== 8'h00) begin n_fail++; $display("FAIL reset_dato: got %h expected 00", dato); end
    n_checks++; if (dest_out !== 3'd0) begin n_fail++; $display("FAIL reset_dest: got %0d expected 0", dest_out); end
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %b expected 0", sel_err); end
    n_checks++; if (tx !== 8'd0) begin n_fail++; $display("FAIL reset_tx: got %0d expected 0", tx); end
  endtask

  task automatic test_walk();
    data_in = 8'd0; direccion = 8'd1; num = 3'd2; ry = 8'd3; resultado = 8'd4;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int s = 0; s < 5; s++) begin
      sel  = 3'(s);
      dest = 3'(s);
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL walk_valid[%0d]: got %b expected 1", s, out_valid); end
      n_checks++; if (dato !== 8'(s) || dest_out !== 3'(s) || sel_err !== 1'b0) begin
        n_fail++; $display("FAIL walk_word[%0d]: got %h/%0d/%b expected %h/%0d/0", s, dato, dest_out, sel_err, 8'(s), s);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (tx !== 8'd5) begin n_fail++; $display("FAIL walk_tx: got %0d expected 5", tx); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL walk_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 3'd5; ry = 8'hAA; dest = 3'd7;
    tick();
    n_checks++; if (dato !== 8'h00 || sel_err !== 1'b1 || out_valid !== 1'b1 || dest_out !== 3'd7) begin
      n_fail++; $display("FAIL illegal_word: got %h/%b/%b/%0d expected 00/1/1/7", dato, sel_err, out_valid, dest_out);
    end
    out_ready = 1'b1;
    sel = 3'd3; dest = 3'd2;
    tick();
    n_checks++; if (dato !== 8'hAA || sel_err !== 1'b0 || dest_out !== 3'd2) begin
      n_fail++; $display("FAIL illegal_next: got %h/%b/%0d expected aa/0/2", dato, sel_err, dest_out);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [7:0] seen[3];
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 3'd3; ry = 8'd3; dest = 3'd1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready1: got %b expected 1", in_ready); end
    sel = 3'd4; resultado = 8'd4; dest = 3'd2;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready2: got %b expected 0", in_ready); end
    sel = 3'd0; data_in = 8'd9; dest = 3'd3;
    for (int i = 0; i < 3; i++) begin
      ry = 8'($urandom); resultado = 8'($urandom);
      tick();
      n_checks++; if (dato !== 8'd3 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h/%b expected 03/0", i, dato, in_ready);
      end
    end
    out_ready = 1'b1;
    seen[0] = dato;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_reopen: got %b expected 1", in_ready); end
    seen[1] = dato;
    tick();
    in_valid = 1'b0;
    seen[2] = dato;
    tick();
    n_checks++; if (seen[0] !== 8'd3 || seen[1] !== 8'd4 || seen[2] !== 8'd9) begin
      n_fail++; $display("FAIL stall_order: got %h %h %h expected 03 04 09", seen[0], seen[1], seen[2]);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    bit wrapped = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    randomize_sources();
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      randomize_sources();
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || q.size() != 1) begin
        n_fail++; $display("FAIL b2b_level[%0d]: got valid=%b ready=%b expected 1/1", i, out_valid, in_ready);
      end
      n_checks++; if ({dato, dest_out, sel_err} !== q[0]) begin
        n_fail++; $display("FAIL b2b_head[%0d]: got %h/%0d/%b expected %h/%0d/%b", i, dato, dest_out, sel_err, q[0].w, q[0].d, q[0].e);
      end
      tick();
      if (tx_exp % 256 == 0) begin
        wrapped = 1;
        n_checks++; if (tx !== 8'd0) begin n_fail++; $display("FAIL b2b_wrap: got %0d expected 0", tx); end
      end
    end
    n_checks++; if (!wrapped || tx !== 8'(tx_exp)) begin
      n_fail++; $display("FAIL b2b_tx: got %0d expected %0d (wrap seen %0d)", tx, 8'(tx_exp), wrapped);
    end
    drain();
  endtask

  task automatic test_num_ext();
    logic [7:0] want;
`ifdef DATA_SEL_SIGNEXT_EN
    want = 8'hFE;
`else
    want = 8'h06;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel = 3'd2; num = 3'b110; dest = 3'd5;
    tick();
    in_valid = 1'b0;
    n_checks++; if (dato !== want || sel_err !== 1'b0) begin
      n_fail++; $display("FAIL num_ext: got %h/%b expected %h/0", dato, sel_err, want);
    end
    num = 3'b011;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (dato !== 8'h03) begin n_fail++; $display("FAIL num_ext_pos: got %h expected 03", dato); end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 3'd4; resultado = 8'h77; dest = 3'd4;
    repeat (3) tick();
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_full: got ready=%b valid=%b expected 0/1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    q.delete(); tx_exp = 0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dato !== 8'h00 || dest_out !== 3'd0 || sel_err !== 1'b0 || tx !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_async: got valid=%b ready=%b dato=%h dest=%0d err=%b tx=%0d expected 0/1/00/0/0/0",
                         out_valid, in_ready, dato, dest_out, sel_err, tx);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: got %b expected 0", out_valid); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel = 3'd1; direccion = 8'h5C; dest = 3'd6;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || dato !== 8'h5C || dest_out !== 3'd6 || sel_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_first: got %b/%h/%0d/%b expected 1/5c/6/0", out_valid, dato, dest_out, sel_err);
    end
    tick();
    n_checks++; if (tx !== 8'd1) begin n_fail++; $display("FAIL rstmid_tx: got %0d expected 1", tx); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_sources();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      n_checks++; if (in_ready !== (q.size() != 2) || out_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got ready=%b valid=%b expected %b/%b", i, in_ready, out_valid, q.size() != 2, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_checks++; if ({dato, dest_out, sel_err} !== q[0]) begin
          n_fail++; $display("FAIL rand_head[%0d]: got %h/%0d/%b expected %h/%0d/%b", i, dato, dest_out, sel_err, q[0].w, q[0].d, q[0].e);
        end
      end
      n_checks++; if (tx !== 8'(tx_exp)) begin n_fail++; $display("FAIL rand_tx[%0d]: got %0d expected %0d", i, tx, 8'(tx_exp)); end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_walk();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_num_ext();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
